txshift: RTL and testbench

TXSHIFT -- requirements
Module: txshift

---
 rtl/txshift.sv | 97 +++++++++
 tb/tb_txshift.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/txshift.sv
// txshift: UART transmit shifter, frames aligned to rising edges of the baud clock.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module txshift #(
   parameter int g_PARITY    = 0,
   parameter int g_STOP_BITS = 1
) (
   input  logic       i_Pclk,
   input  logic       i_Reset,
   input  logic       i_Bclk,
   input  logic       i_Enable,
   input  logic       i_Start,
   input  logic [7:0] i_Data,
   output logic       o_Tx_Serial,
   output logic       o_Busy,
   output logic       o_Done
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP} state_t;
   state_t     r_state, w_state_n;
   logic       r_bclk, w_tick;
   logic [7:0] r_shift, w_shift_n;
   logic [2:0] r_idx, w_idx_n;
   logic       r_stop, w_stop_n;
   logic       r_par, w_par_n;
   logic       r_tx, w_tx_n;
   logic       r_done, w_done_n;
   logic       w_last_stop;
   assign w_tick      = i_Bclk & ~r_bclk;
   assign w_last_stop = (g_STOP_BITS == 1) | r_stop;
   always_comb begin
      w_state_n = r_state;
      w_shift_n = r_shift;
      w_idx_n   = r_idx;
      w_stop_n  = r_stop;
      w_par_n   = r_par;
      w_done_n  = 1'b0;
      if (r_state != S_IDLE && !i_Enable) begin
         w_state_n = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: if (i_Start && i_Enable) begin
               w_state_n = S_WAIT;
               w_shift_n = i_Data;
               w_par_n   = (^i_Data) ^ (g_PARITY == 2);
            end
            S_WAIT: if (w_tick) w_state_n = S_START;
            S_START: if (w_tick) begin
               w_state_n = S_DATA;
               w_idx_n   = 3'd0;
            end
            S_DATA: if (w_tick) begin
               w_shift_n = {1'b0, r_shift[7:1]};
               w_idx_n   = r_idx + 3'd1;
               w_stop_n  = 1'b0;
               if (r_idx == 3'd7) w_state_n = (g_PARITY != 0) ? S_PARITY : S_STOP;
            end
            S_PARITY: if (w_tick) begin
               w_state_n = S_STOP;
               w_stop_n  = 1'b0;
            end
            S_STOP: if (w_tick) begin
               w_state_n = w_last_stop ? S_IDLE : S_STOP;
               w_done_n  = w_last_stop;
               w_stop_n  = 1'b1;
            end
            default: w_state_n = S_IDLE;
         endcase
      end
      // line value follows the state being entered so the output register stays aligned with it
      w_tx_n = (w_state_n == S_START)  ? 1'b0 :
               (w_state_n == S_DATA)   ? w_shift_n[0] :
               (w_state_n == S_PARITY) ? w_par_n : 1'b1;
   end
   always_ff @(posedge i_Pclk) begin
      if (i_Reset) begin
         r_state <= S_IDLE;
         r_bclk  <= 1'b1;
         r_shift <= 8'd0;
         r_idx   <= 3'd0;
         r_stop  <= 1'b0;
         r_par   <= 1'b0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_bclk  <= i_Bclk;
         r_shift <= w_shift_n;
         r_idx   <= w_idx_n;
         r_stop  <= w_stop_n;
         r_par   <= w_par_n;
         r_tx    <= w_tx_n;
         r_done  <= w_done_n;
      end
   end
   assign o_Tx_Serial = r_tx;
   assign o_Busy      = (r_state != S_IDLE);
   assign o_Done      = r_done;
endmodule

// File: tb/tb_txshift.sv
// tb_txshift: three transmitters (no parity/1 stop, even/2 stop, odd/1 stop) checked against a frame-array model.
module tb_txshift;
   localparam int BIT = 174;
   logic       i_Pclk = 1'b0, i_Reset = 1'b1, i_Bclk = 1'b0, i_Enable = 1'b0, i_Start = 1'b0;
   logic [7:0] i_Data = 8'h00;
   logic [2:0] tx, busy, done;
   int total = 0, bad = 0;
   bit chk_on = 1'b0;
   txshift u0 (.i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Bclk(i_Bclk), .i_Enable(i_Enable), .i_Start(i_Start),
               .i_Data(i_Data), .o_Tx_Serial(tx[0]), .o_Busy(busy[0]), .o_Done(done[0]));
   txshift #(.g_PARITY(1), .g_STOP_BITS(2)) u1 (.i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Bclk(i_Bclk),
               .i_Enable(i_Enable), .i_Start(i_Start), .i_Data(i_Data), .o_Tx_Serial(tx[1]), .o_Busy(busy[1]), .o_Done(done[1]));
   txshift #(.g_PARITY(2), .g_STOP_BITS(1)) u2 (.i_Pclk(i_Pclk), .i_Reset(i_Reset), .i_Bclk(i_Bclk),
               .i_Enable(i_Enable), .i_Start(i_Start), .i_Data(i_Data), .o_Tx_Serial(tx[2]), .o_Busy(busy[2]), .o_Done(done[2]));
   always #50 i_Pclk = ~i_Pclk;
   initial forever #(BIT * 50) i_Bclk = ~i_Bclk;
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
      end
   endtask
   function automatic int par_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 1 : 2;
   endfunction
   function automatic int stop_of(input int d);
      return (d == 1) ? 2 : 1;
   endfunction
   function automatic logic [11:0] frame(input logic [7:0] v, input int p);
      logic [11:0] f;
      f      = '1;
      f[0]   = 1'b0;
      f[8:1] = v;
      if (p != 0) f[9] = (^v) ^ (p == 2);
      return f;
   endfunction
   // model: a frame is a list of line bits; each baud rising edge steps to the next bit
   logic        m_prev;
   logic [2:0]  m_idle, m_tx, m_done;
   logic [11:0] m_bits[3];
   int          m_pos[3], m_n[3];
   logic        m_tick;
   assign m_tick = i_Bclk & ~m_prev;
   always @(posedge i_Pclk) begin
      m_prev <= i_Reset ? 1'b1 : i_Bclk;
      for (int d = 0; d < 3; d++) begin
         if (i_Reset) begin
            m_idle[d] <= 1'b1;
            m_tx[d]   <= 1'b1;
            m_done[d] <= 1'b0;
         end else begin
            m_done[d] <= 1'b0;
            if (!m_idle[d] && !i_Enable) begin
               m_idle[d] <= 1'b1;
               m_tx[d]   <= 1'b1;
            end else if (m_idle[d]) begin
               if (i_Start && i_Enable) begin
                  m_idle[d] <= 1'b0;
                  m_bits[d] <= frame(i_Data, par_of(d));
                  m_n[d]    <= 9 + ((par_of(d) != 0) ? 1 : 0) + stop_of(d);
                  m_pos[d]  <= -1;
                  m_tx[d]   <= 1'b1;
               end
            end else if (m_tick) begin
               m_pos[d] <= m_pos[d] + 1;
               if (m_pos[d] + 1 == m_n[d]) begin
                  m_idle[d] <= 1'b1;
                  m_done[d] <= 1'b1;
                  m_tx[d]   <= 1'b1;
               end else begin
                  m_tx[d] <= m_bits[d][m_pos[d] + 1];
               end
            end
         end
      end
   end
   always @(negedge i_Pclk)
      if (chk_on) chk("cycle {tx,busy,done}", {23'd0, tx, busy, done}, {23'd0, m_tx, ~m_idle, m_done});
   logic [11:0] cb[3];
   int          cl[3], ch[3];
   task automatic capture(input logic [2:0] m);
      int n, cnt;
      int last[3];
      logic [2:0] fin;
      n = 0;
      while (tx[0] !== 1'b0 && n < 3000) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("start_seen", {31'd0, n < 3000}, 32'd1);
      fin = ~m;
      cnt = 0;
      for (int d = 0; d < 3; d++) begin
         cb[d] = '0; cl[d] = -1; ch[d] = -1; last[d] = 0;
      end
      while (fin != 3'b111 && cnt < 2600) begin
         for (int d = 0; d < 3; d++) begin
            if (!fin[d]) begin
               if (cnt % BIT == BIT / 2 && cnt / BIT < 12) cb[d][cnt / BIT] = tx[d];
               if (tx[d] === 1'b0) last[d] = cnt;
               if (done[d] === 1'b1) begin
                  fin[d] = 1'b1;
                  cl[d]  = cnt;
                  ch[d]  = cnt - last[d] - 1;
               end
            end
         end
         if (fin != 3'b111) begin
            @(negedge i_Pclk);
            cnt++;
         end
      end
   endtask
   task automatic send(input logic [7:0] v);
      @(negedge i_Pclk);
      i_Data  = v;
      i_Start = 1'b1;
      @(negedge i_Pclk);
      i_Start = 1'b0;
   endtask
   task automatic wait_idle();
      int n;
      n = 0;
      while (busy !== 3'b000 && n < 3000) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("idle_reached", {31'd0, n < 3000}, 32'd1);
   endtask
   task automatic wait_low();
      int n;
      n = 0;
      while (tx[0] !== 1'b0 && n < 3000) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("start_low", {31'd0, n < 3000}, 32'd1);
   endtask
   initial begin
      int n;
      repeat (3) @(negedge i_Pclk);
      i_Reset = 1'b0;
      chk_on  = 1'b1;
      chk("rst_tx", {29'd0, tx}, 32'h7);
      chk("rst_busy", {29'd0, busy}, 32'h0);
      chk("rst_done", {29'd0, done}, 32'h0);
      i_Enable = 1'b1;
      // 0x53 in all three parity/stop modes
      send(8'h53);
      capture(3'b111);
      chk("f53_bits_u0", cb[0], 12'h2A6);
      chk("f53_byte_u0", cb[0][8:1], 8'h53);
      chk("f53_len_u0", cl[0], 1740);
      chk("f53_stop_u0", ch[0], 174);
      chk("f53_bits_u1", cb[1], 12'hCA6);
      chk("f53_len_u1", cl[1], 2088);
      chk("f53_stop_u1", ch[1], 348);
      chk("f53_bits_u2", cb[2], 12'h6A6);
      chk("f53_len_u2", cl[2], 1914);
      wait_idle();
      // restart and data change mid-frame are ignored; parity from latched byte
      send(8'h11);
      fork
         capture(3'b111);
         begin
            repeat (3 * BIT) @(negedge i_Pclk);
            i_Data  = 8'hEE;
            i_Start = 1'b1;
            @(negedge i_Pclk);
            i_Start = 1'b0;
            i_Data  = 8'hFE;
         end
      join
      chk("ign_bits_u0", cb[0], 12'h222);
      chk("ign_len_u0", cl[0], 1740);
      chk("ign_bits_u1", cb[1], 12'hC22);
      chk("ign_bits_u2", cb[2], 12'h622);
      wait_idle();
      // back-to-back: second request in the o_Done cycle
      send(8'hA5);
      n = 0;
      while (done[0] !== 1'b1 && n < 3000) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("b2b_done_seen", {31'd0, n < 3000}, 32'd1);
      chk("b2b_busy_in_done", {31'd0, busy[0]}, 32'd0);
      i_Data  = 8'h3C;
      i_Start = 1'b1;
      @(negedge i_Pclk);
      i_Start = 1'b0;
      i_Data  = 8'h00;
      n = 1;
      while (tx[0] !== 1'b0 && n < 400) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("b2b_gap", n, 174);
      capture(3'b001);
      chk("b2b_bits_u0", cb[0], 12'h278);
      chk("b2b_len_u0", cl[0], 1740);
      wait_idle();
      // request coincident with a baud tick waits for the next tick
      @(posedge i_Bclk);
      i_Data  = 8'h81;
      i_Start = 1'b1;
      @(posedge i_Pclk);
      @(negedge i_Pclk);
      i_Start = 1'b0;
      chk("tick_busy", {29'd0, busy}, 32'h7);
      chk("tick_line", {29'd0, tx}, 32'h7);
      n = 0;
      while (tx[0] !== 1'b0 && n < 400) begin
         @(negedge i_Pclk);
         n++;
      end
      chk("tick_delay", n, 174);
      capture(3'b111);
      chk("tick_bits_u0", cb[0], 12'h302);
      wait_idle();
      // enable dropped in data bit 3 aborts
      send(8'h53);
      wait_low();
      repeat (4 * BIT + BIT / 2) @(negedge i_Pclk);
      i_Enable = 1'b0;
      @(negedge i_Pclk);
      chk("abort_tx", {29'd0, tx}, 32'h7);
      chk("abort_busy", {29'd0, busy}, 32'h0);
      chk("abort_done", {29'd0, done}, 32'h0);
      i_Enable = 1'b1;
      repeat (400) @(negedge i_Pclk);
      // reset mid-frame
      send(8'h53);
      wait_low();
      repeat (4 * BIT + BIT / 2) @(negedge i_Pclk);
      i_Reset = 1'b1;
      @(negedge i_Pclk);
      chk("rstmid_tx", {29'd0, tx}, 32'h7);
      chk("rstmid_busy", {29'd0, busy}, 32'h0);
      chk("rstmid_done", {29'd0, done}, 32'h0);
      i_Reset = 1'b0;
      repeat (400) @(negedge i_Pclk);
      // start with enable low is ignored
      i_Enable = 1'b0;
      send(8'h55);
      chk("dis_busy", {29'd0, busy}, 32'h0);
      repeat (BIT) @(negedge i_Pclk);
      chk("dis_line", {29'd0, tx}, 32'h7);
      i_Enable = 1'b1;
      repeat (10) @(negedge i_Pclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
